// File: rtl/wr_arb_pkg.sv
// Shared types and helpers for the write-port arbiter/mux.
package wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index of the set bit of a one-hot vector (0 when empty).
    function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            idx = idx | (oh[i] ? 5'(i) : 5'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set request at or after start_idx_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_idx_i,
    output logic [N-1:0]  onehot_o,
    output logic          valid_o
);

    logic [N-1:0] rot_s;
    logic [N-1:0] pick_s;

    // Rotate so start_idx_i sits at bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        rot_s    = (req_i >> start_idx_i) | (req_i << (N - int'(start_idx_i)));
        pick_s   = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
        onehot_o = (pick_s << start_idx_i) | (pick_s >> (N - int'(start_idx_i)));
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/wr_arb_mux.sv
// N-channel write arbiter/mux: grants ownership of the shared write port and
// forwards the owner's write stream with one register stage.
module wr_arb_mux
    import wr_arb_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DW         = 8,
    parameter int MODE       = 0,
    parameter int GAP_CYCLES = 1,
    parameter int MAX_HOLD   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    sel,
    input  logic [N_CH-1:0]    ch_wr_en,
    input  logic [N_CH*DW-1:0] ch_wr_data,
    output logic               wr_en,
    output logic [DW-1:0]      wr_data,
    output logic [N_CH-1:0]    grant,
    output logic               busy,
    output logic               drop,
    output logic               hold_timeout
);

    localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [3:0]     GAP_LAST  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0]  PTR_RST   = IW'(N_CH - 1);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [HCW-1:0]    hold_q, hold_d;
    logic [3:0]        gap_q, gap_d;
    logic              wr_en_q, wr_en_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic              drop_q, drop_d;
    logic              to_q, to_d;

    logic [IW-1:0]     start_s;
    logic [N_CH-1:0]   pick_s;
    logic              pick_vld_s;
    logic              own_sel_s;
    logic              own_wen_s;
    logic [DW-1:0]     own_data_s;
    logic [IW-1:0]     own_idx_s;
    logic              hold_hit_s;

    // Search start: just after the last released owner in RR, always ch0 in fixed mode.
    always_comb begin
        if (MODE == MODE_RR) begin
            start_s = (ptr_q == PTR_RST) ? '0 : ptr_q + IW'(1);
        end else begin
            start_s = '0;
        end
    end

    rr_pick #(.N(N_CH), .IW(IW)) u_pick (
        .req_i       (sel),
        .start_idx_i (start_s),
        .onehot_o    (pick_s),
        .valid_o     (pick_vld_s)
    );

    // Owner's request, strobe and data selected through the one-hot grant.
    always_comb begin
        own_data_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            own_data_s = own_data_s | (ch_wr_data[i*DW +: DW] & {DW{grant_q[i]}});
        end
        own_sel_s  = |(sel & grant_q);
        own_wen_s  = |(ch_wr_en & sel & grant_q);
        own_idx_s  = IW'(onehot2idx(32'(grant_q)));
        hold_hit_s = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);
    end

    // State register and all output/counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= PTR_RST;
            hold_q    <= '0;
            gap_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            drop_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
            to_q      <= to_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = pick_vld_s ? ST_OWN : ST_IDLE;
            ST_OWN: begin
                if (!own_sel_s || hold_hit_s) begin
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_d = ST_OWN;
                end
            end
            ST_GAP:  state_d = (gap_q == GAP_LAST) ? ST_IDLE : ST_GAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, counters and the forwarded write; a release by dropped sel discards that cycle's write.
    always_comb begin
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        wr_en_d   = 1'b0;
        wr_data_d = '0;
        to_d      = 1'b0;
        drop_d    = |(ch_wr_en & ~grant_q);
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    grant_d = pick_s;
                    hold_d  = '0;
                end else begin
                    grant_d = '0;
                end
            end
            ST_OWN: begin
                hold_d = hold_q + HCW'(1);
                if (!own_sel_s) begin
                    grant_d = '0;
                    ptr_d   = own_idx_s;
                    gap_d   = '0;
                end else begin
                    wr_en_d   = own_wen_s;
                    wr_data_d = own_wen_s ? own_data_s : '0;
                    if (hold_hit_s) begin
                        grant_d = '0;
                        ptr_d   = own_idx_s;
                        gap_d   = '0;
                        to_d    = 1'b1;
                    end else begin
                        grant_d = grant_q;
                    end
                end
            end
            ST_GAP: begin
                grant_d = '0;
                gap_d   = gap_q + 4'd1;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    assign wr_en        = wr_en_q;
    assign wr_data      = wr_data_q;
    assign grant        = grant_q;
    assign busy         = (state_q != ST_IDLE);
    assign drop         = drop_q;
    assign hold_timeout = to_q;

endmodule

// File: tb/tb_wr_arb_mux.sv
// Bench for wr_arb_mux: an RR instance (GAP=1, MAX_HOLD=5) and a fixed-priority
// instance (GAP=0, unlimited hold) share stimulus and are checked against a model.
module tb_wr_arb_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sel, ch_wr_en;
    logic [31:0] ch_wr_data;

    logic        rr_wen, rr_busy, rr_drop, rr_to;
    logic [7:0]  rr_data;
    logic [3:0]  rr_grant;
    logic        fx_wen, fx_busy, fx_drop, fx_to;
    logic [7:0]  fx_data;
    logic [3:0]  fx_grant;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    wr_arb_mux #(.N_CH(4), .DW(8), .MODE(1), .GAP_CYCLES(1), .MAX_HOLD(5)) dut_rr (
        .clk(clk), .reset(reset), .sel(sel), .ch_wr_en(ch_wr_en), .ch_wr_data(ch_wr_data),
        .wr_en(rr_wen), .wr_data(rr_data), .grant(rr_grant), .busy(rr_busy),
        .drop(rr_drop), .hold_timeout(rr_to)
    );

    wr_arb_mux #(.N_CH(4), .DW(8), .MODE(0), .GAP_CYCLES(0), .MAX_HOLD(0)) dut_fx (
        .clk(clk), .reset(reset), .sel(sel), .ch_wr_en(ch_wr_en), .ch_wr_data(ch_wr_data),
        .wr_en(fx_wen), .wr_data(fx_data), .grant(fx_grant), .busy(fx_busy),
        .drop(fx_drop), .hold_timeout(fx_to)
    );

    // Model: who owns the port, how long it has owned it, gap cycles left, last released owner.
    typedef struct {
        int         owner;
        int         owned;
        int         gap_left;
        int         last;
        bit         wen;
        logic [7:0] data;
        bit         drop;
        bit         to;
    } m_t;

    m_t m_rr, m_fx;

    function automatic logic [3:0] oh(input int o);
        return (o < 0) ? 4'b0000 : 4'(1 << o);
    endfunction

    function automatic m_t step(input m_t m, input int mode, input int gapc, input int maxh,
                                input logic rst, input logic [3:0] s, input logic [3:0] en,
                                input logic [31:0] d);
        m_t n;
        n = m;
        n.wen = 1'b0; n.data = 8'h00; n.to = 1'b0;
        if (rst) begin
            n.owner = -1; n.owned = 0; n.gap_left = 0; n.last = 3; n.drop = 1'b0;
            return n;
        end
        n.drop = |(en & ~oh(m.owner));
        if (m.owner >= 0) begin
            if (!s[m.owner]) begin
                n.owner = -1; n.last = m.owner; n.gap_left = gapc;
            end else begin
                n.wen   = en[m.owner];
                n.data  = en[m.owner] ? d[m.owner*8 +: 8] : 8'h00;
                n.owned = m.owned + 1;
                if (maxh > 0 && n.owned == maxh) begin
                    n.owner = -1; n.last = m.owner; n.gap_left = gapc; n.to = 1'b1;
                end
            end
        end else if (m.gap_left > 0) begin
            n.gap_left = m.gap_left - 1;
        end else if (s != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (mode == 1) ? (m.last + 1 + k) % 4 : k;
                if (n.owner < 0 && s[idx]) n.owner = idx;
            end
            n.owned = 0;
        end
        return n;
    endfunction

    function automatic logic [15:0] expv(input m_t m);
        return {m.wen, m.data, oh(m.owner), (m.owner >= 0 || m.gap_left > 0), m.drop, m.to};
    endfunction

    always @(posedge clk) begin
        m_rr = step(m_rr, 1, 1, 5, reset, sel, ch_wr_en, ch_wr_data);
        m_fx = step(m_fx, 0, 0, 0, reset, sel, ch_wr_en, ch_wr_data);
        if (reset) started = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            n_checks++;
            if ({rr_wen, rr_data, rr_grant, rr_busy, rr_drop, rr_to} !== expv(m_rr)) begin
                n_fail++;
                $display("FAIL model_rr t=%0t: got {wen,data,grant,busy,drop,to}=%h, expected %h",
                         $time, {rr_wen, rr_data, rr_grant, rr_busy, rr_drop, rr_to}, expv(m_rr));
            end
            n_checks++;
            if ({fx_wen, fx_data, fx_grant, fx_busy, fx_drop, fx_to} !== expv(m_fx)) begin
                n_fail++;
                $display("FAIL model_fx t=%0t: got {wen,data,grant,busy,drop,to}=%h, expected %h",
                         $time, {fx_wen, fx_data, fx_grant, fx_busy, fx_drop, fx_to}, expv(m_fx));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wc, tc, cnt;
        logic [3:0] prev;
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};

        reset = 1'b1; sel = 4'b0000; ch_wr_en = 4'b0000; ch_wr_data = 32'h0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_idle_rr", 32'({rr_wen, rr_data, rr_grant, rr_busy}), 32'h0);
        end

        // Fixed priority grant, forwarding and drop.
        sel = 4'b1010;
        tick();
        chk("grant_fx_1010", 32'(fx_grant), 32'h2);
        chk("grant_rr_1010", 32'(rr_grant), 32'h2);
        ch_wr_en = 4'b0010; ch_wr_data = 32'h0000_A500;
        tick();
        chk("wr_A5", 32'({fx_wen, fx_data}), 32'h1A5);
        ch_wr_en = 4'b1010; ch_wr_data = 32'hFF00_5A00;
        tick();
        chk("wr_5A", 32'({fx_wen, fx_data}), 32'h15A);
        chk("drop_ch3", 32'(fx_drop), 32'h1);
        ch_wr_en = 4'b0000; ch_wr_data = 32'h0;
        tick();
        chk("idle_after_writes", 32'({fx_wen, fx_data, fx_drop}), 32'h0);
        sel = 4'b0000;
        tick();
        chk("release_fx", 32'(fx_grant), 32'h0);
        repeat (4) tick();

        // Hold limit on the RR instance.
        sel = 4'b0100; ch_wr_en = 4'b0100; wc = 0; tc = 0;
        for (int i = 0; i < 8; i++) begin
            ch_wr_data = $urandom;
            tick();
            wc += int'(rr_wen);
            tc += int'(rr_to);
        end
        chk("hold_writes", 32'(wc), 32'd5);
        chk("hold_timeouts", 32'(tc), 32'd1);
        chk("hold_regrant", 32'(rr_grant), 32'h4);
        sel = 4'b0000; ch_wr_en = 4'b0000;
        repeat (4) tick();

        // Reset during an active transfer restarts RR from ch0.
        sel = 4'b1000; ch_wr_en = 4'b1000; ch_wr_data = 32'h3C00_0000;
        tick(); tick(); tick();
        chk("own_ch3_wen", 32'({rr_wen, rr_data}), 32'h13C);
        reset = 1'b1;
        tick();
        chk("midreset_outs", 32'({rr_wen, rr_data, rr_grant, rr_busy, rr_drop, rr_to}), 32'h0);
        reset = 1'b0; sel = 4'b1001; ch_wr_en = 4'b0000;
        tick();
        chk("rr_after_reset", 32'(rr_grant), 32'h1);

        // RR rotation: each owner drops sel for one cycle after three writes.
        sel = 4'b1111; ch_wr_en = 4'b1111; prev = 4'b0000; cnt = 0;
        for (int i = 0; i < 45; i++) begin
            ch_wr_data = $urandom;
            tick();
            if (rr_grant != 4'b0000) begin
                if (rr_grant == prev) begin
                    cnt++;
                end else begin
                    for (int b = 0; b < 4; b++) if (rr_grant[b]) order.push_back(b);
                    cnt = 1;
                end
                prev = rr_grant;
                sel  = (cnt == 4) ? ~rr_grant : 4'b1111;
            end else begin
                prev = 4'b0000;
                sel  = 4'b1111;
            end
        end
        chk("rr_order_len", 32'(order.size() >= 5), 32'h1);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF, 32'(exp_order[k]));
        end

        // GAP_CYCLES=0 handover on the fixed instance.
        reset = 1'b1; sel = 4'b0000; ch_wr_en = 4'b0000;
        tick();
        reset = 1'b0; sel = 4'b0011;
        tick();
        chk("fx_grant_ch0", 32'(fx_grant), 32'h1);
        sel = 4'b0010;
        tick();
        chk("fx_release_idle", 32'({fx_grant, fx_busy}), 32'h0);
        tick();
        chk("fx_handover", 32'(fx_grant), 32'h2);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) sel[b] = ~sel[b];
            ch_wr_en   = 4'($urandom);
            ch_wr_data = $urandom;
            reset      = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; sel = 4'b0000; ch_wr_en = 4'b0000;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
